// File: rtl/zion_basic_circuit_lib_pkg.sv
// Shared constants and helpers for the zion basic circuit library.
// Holds parameter limits and the occupancy count width function.
package zion_basic_circuit_lib_pkg;

  localparam int ZION_WIDTH_MIN = 1;
  localparam int ZION_WIDTH_MAX = 1024;
  localparam int ZION_DEPTH_MIN = 1;
  localparam int ZION_DEPTH_MAX = 64;

  // Bits needed to count 0..depth occupied stages.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // True when WIDTH/DEPTH fall inside the supported range.
  function automatic bit cfg_ok(input int width, input int depth);
    return (width >= ZION_WIDTH_MIN) && (width <= ZION_WIDTH_MAX) &&
           (depth >= ZION_DEPTH_MIN) && (depth <= ZION_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/zion_clr_vld_stage.sv
// One pipeline stage: valid bit plus data register.
// Supports load, drain (leave without refill) and synchronous clear.
module zion_clr_vld_stage
  import zion_basic_circuit_lib_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] INI_DATA = '0
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             iClr,
  input  logic             iLd,
  input  logic             iLv,
  input  logic [WIDTH-1:0] iDat,
  output logic             oVld,
  output logic [WIDTH-1:0] oDat
);

  logic             vld_d;
  logic             vld_q;
  logic [WIDTH-1:0] dat_d;
  logic [WIDTH-1:0] dat_q;

  // Next state: clear wins, then load, then drain keeps data.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (iClr) begin
      vld_d = 1'b0;
      dat_d = INI_DATA;
    end else if (iLd) begin
      vld_d = 1'b1;
      dat_d = iDat;
    end else if (iLv) begin
      vld_d = 1'b0;
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= INI_DATA;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign oVld = vld_q;
  assign oDat = dat_q;

endmodule

// File: rtl/zion_clr_vld_pipe.sv
// Valid/ready pipeline with bubble collapsing and synchronous flush.
// Macro ZION_CLR_VLD_PIPE_OCC_CNT_EN enables the occupancy counter.
module zion_clr_vld_pipe
  import zion_basic_circuit_lib_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] INI_DATA = '0,
  localparam int              CW       = cnt_w(DEPTH)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             iClr,
  input  logic             iVld,
  output logic             oRdy,
  input  logic [WIDTH-1:0] iDat,
  output logic             oVld,
  input  logic             iRdy,
  output logic [WIDTH-1:0] oDat,
  output logic [CW-1:0]    oCnt
);

  if (!cfg_ok(WIDTH, DEPTH)) begin : g_bad_cfg
`ifdef CHECK_ERR_EXIT
    $fatal(1, "zion_clr_vld_pipe: WIDTH=%0d DEPTH=%0d illegal",
           WIDTH, DEPTH);
`else
    $error("zion_clr_vld_pipe: WIDTH=%0d DEPTH=%0d illegal",
           WIDTH, DEPTH);
`endif
  end

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] lv;
  logic [DEPTH-1:0] cl;
  logic [DEPTH-1:0] ld;
  logic             rdy;
  logic [WIDTH-1:0] dat [DEPTH];

  // Ready chain from the output back to stage 0; collapses bubbles.
  always_comb begin
    lv = '0;
    cl = '0;
    ld = '0;
    lv[DEPTH-1] = vld[DEPTH-1] && !iClr && iRdy;
    cl[DEPTH-1] = !vld[DEPTH-1] || lv[DEPTH-1];
    for (int k = DEPTH - 2; k >= 0; k--) begin
      lv[k] = vld[k] && cl[k+1];
      cl[k] = !vld[k] || lv[k];
    end
    rdy   = cl[0] && !iClr;
    ld[0] = iVld && rdy;
    for (int k = 1; k < DEPTH; k++) begin
      ld[k] = lv[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stg
    logic [WIDTH-1:0] din;
    if (k == 0) begin : g_head
      assign din = iDat;
    end else begin : g_body
      assign din = dat[k-1];
    end
    zion_clr_vld_stage #(
      .WIDTH    (WIDTH),
      .INI_DATA (INI_DATA)
    ) u_stg (
      .clk  (clk),
      .rst  (rst),
      .iClr (iClr),
      .iLd  (ld[k]),
      .iLv  (lv[k]),
      .iDat (din),
      .oVld (vld[k]),
      .oDat (dat[k])
    );
  end

  assign oRdy = rdy;
  assign oVld = vld[DEPTH-1] && !iClr;
  assign oDat = dat[DEPTH-1];

`ifdef ZION_CLR_VLD_PIPE_OCC_CNT_EN
  logic          in_x;
  logic          out_x;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  assign in_x  = iVld && rdy;
  assign out_x = oVld && iRdy;

  // Occupancy: up on input-only, down on output-only transfer.
  always_comb begin
    cnt_d = cnt_q;
    if (iClr) begin
      cnt_d = '0;
    end else if (in_x && !out_x) begin
      cnt_d = cnt_q + CW'(1);
    end else if (out_x && !in_x) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Occupancy register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oCnt = cnt_q;
`else
  assign oCnt = '0;
`endif

endmodule

// File: tb/tb_zion_clr_vld_pipe.sv
// Directed bench for zion_clr_vld_pipe (WIDTH=8, DEPTH=3, INI=5A).
// Occupancy expectations follow ZION_CLR_VLD_PIPE_OCC_CNT_EN.
module tb_zion_clr_vld_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       iClr;
  logic       iVld;
  logic       oRdy;
  logic [7:0] iDat;
  logic       oVld;
  logic       iRdy;
  logic [7:0] oDat;
  logic [1:0] oCnt;

  int errors = 0;
  int checks = 0;

  zion_clr_vld_pipe #(
    .WIDTH    (8),
    .DEPTH    (3),
    .INI_DATA (8'h5A)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .iClr (iClr),
    .iVld (iVld),
    .oRdy (oRdy),
    .iDat (iDat),
    .oVld (oVld),
    .iRdy (iRdy),
    .oDat (oDat),
    .oCnt (oCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ec(input int n);
`ifdef ZION_CLR_VLD_PIPE_OCC_CNT_EN
    return 2'(n);
`else
    return 2'(n - n);
`endif
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; iClr = 1'b0; iVld = 1'b0;
    iRdy = 1'b0; iDat = 8'h00;
    nxt();
    nxt();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (oVld !== 1'b0) begin
      errors++; $display("FAIL rst_vld got %b want 0", oVld);
    end
    checks++;
    if (oDat !== 8'h5A) begin
      errors++; $display("FAIL rst_dat got %h want 5a", oDat);
    end
    checks++;
    if (oCnt !== 2'd0) begin
      errors++; $display("FAIL rst_cnt got %0d want 0", oCnt);
    end
    checks++;
    if (oRdy !== 1'b1) begin
      errors++; $display("FAIL rst_rdy got %b want 1", oRdy);
    end
    nxt();
  endtask

  task automatic test_stream();
    int nin;
    int nout;
    for (int j = 0; j < 13; j++) begin
      iVld = (j < 10);
      iDat = 8'(j + 1);
      iRdy = 1'b1;
      nin  = (j < 10) ? j : 10;
      nout = (j > 3) ? j - 3 : 0;
      @(negedge clk);
      checks++;
      if (oVld !== (j >= 3)) begin
        errors++;
        $display("FAIL strm_vld c%0d got %b want %b", j, oVld, j >= 3);
      end
      if (j >= 3) begin
        checks++;
        if (oDat !== 8'(j - 2)) begin
          errors++;
          $display("FAIL strm_dat c%0d got %h want %h", j, oDat, 8'(j - 2));
        end
      end
      checks++;
      if (oCnt !== ec(nin - nout)) begin
        errors++;
        $display("FAIL strm_cnt c%0d got %0d want %0d",
                 j, oCnt, ec(nin - nout));
      end
      checks++;
      if (oRdy !== 1'b1) begin
        errors++; $display("FAIL strm_rdy c%0d got %b want 1", j, oRdy);
      end
      nxt();
    end
    iVld = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'd1; exp_d[1] = 8'd2;
    exp_d[2] = 8'd3; exp_d[3] = 8'd4;
    iRdy = 1'b0;
    for (int j = 0; j < 4; j++) begin
      iVld = 1'b1;
      iDat = 8'(j + 1);
      @(negedge clk);
      checks++;
      if (oRdy !== (j < 3)) begin
        errors++;
        $display("FAIL bp_rdy c%0d got %b want %b", j, oRdy, j < 3);
      end
      nxt();
    end
    @(negedge clk);
    checks++;
    if (oCnt !== ec(3)) begin
      errors++; $display("FAIL bp_cnt got %0d want %0d", oCnt, ec(3));
    end
    nxt();
    iRdy = 1'b1;
    for (int j = 0; j < 5; j++) begin
      iVld = (j == 0);
      iDat = 8'd4;
      @(negedge clk);
      if (j == 0) begin
        checks++;
        if (oRdy !== 1'b1) begin
          errors++; $display("FAIL bp_rdy_rel got %b want 1", oRdy);
        end
      end
      checks++;
      if (oVld !== (j < 4)) begin
        errors++;
        $display("FAIL bp_vld c%0d got %b want %b", j, oVld, j < 4);
      end
      if (j < 4) begin
        checks++;
        if (oDat !== exp_d[j]) begin
          errors++;
          $display("FAIL bp_dat c%0d got %h want %h", j, oDat, exp_d[j]);
        end
      end
      nxt();
    end
    iVld = 1'b0;
  endtask

  task automatic test_bubble();
    iRdy = 1'b0;
    for (int j = 0; j < 6; j++) begin
      iVld = (j == 0) || (j == 3);
      iDat = (j == 0) ? 8'hA1 : 8'hB2;
      nxt();
    end
    iVld = 1'b0;
    @(negedge clk);
    checks++;
    if (oVld !== 1'b1 || oDat !== 8'hA1) begin
      errors++;
      $display("FAIL bub_head got %b/%h want 1/a1", oVld, oDat);
    end
    checks++;
    if (oCnt !== ec(2)) begin
      errors++; $display("FAIL bub_cnt got %0d want %0d", oCnt, ec(2));
    end
    checks++;
    if (oRdy !== 1'b1) begin
      errors++; $display("FAIL bub_rdy got %b want 1", oRdy);
    end
    checks++;
    if (u_dut.vld !== 3'b110) begin
      errors++; $display("FAIL bub_stg got %b want 110", u_dut.vld);
    end
    nxt();
    iRdy = 1'b1;
    @(negedge clk);
    checks++;
    if (oVld !== 1'b1 || oDat !== 8'hA1) begin
      errors++;
      $display("FAIL bub_outA got %b/%h want 1/a1", oVld, oDat);
    end
    nxt();
    @(negedge clk);
    checks++;
    if (oVld !== 1'b1 || oDat !== 8'hB2) begin
      errors++;
      $display("FAIL bub_outB got %b/%h want 1/b2", oVld, oDat);
    end
    nxt();
    @(negedge clk);
    checks++;
    if (oVld !== 1'b0) begin
      errors++; $display("FAIL bub_empty got %b want 0", oVld);
    end
    nxt();
  endtask

  task automatic test_clear();
    iRdy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      iVld = (j < 2);
      iDat = (j == 0) ? 8'h11 : 8'h22;
      nxt();
    end
    iClr = 1'b1; iVld = 1'b1; iRdy = 1'b1; iDat = 8'h33;
    @(negedge clk);
    checks++;
    if (oVld !== 1'b0 || oRdy !== 1'b0) begin
      errors++;
      $display("FAIL clr_hs got vld%b rdy%b want 0 0", oVld, oRdy);
    end
    nxt();
    iClr = 1'b0; iVld = 1'b0;
    @(negedge clk);
    checks++;
    if (oVld !== 1'b0 || oDat !== 8'h5A) begin
      errors++;
      $display("FAIL clr_out got %b/%h want 0/5a", oVld, oDat);
    end
    checks++;
    if (oCnt !== 2'd0 || oRdy !== 1'b1) begin
      errors++;
      $display("FAIL clr_cnt got %0d rdy%b want 0 1", oCnt, oRdy);
    end
    nxt();
    nxt();
    @(negedge clk);
    checks++;
    if (oVld !== 1'b0) begin
      errors++; $display("FAIL clr_disc got %b want 0", oVld);
    end
    nxt();
  endtask

  task automatic test_mid_reset();
    iRdy = 1'b0;
    for (int j = 0; j < 4; j++) begin
      iVld = 1'b1;
      iDat = 8'(8'h40 + j);
      nxt();
    end
    rst = 1'b1; iRdy = 1'b1;
    nxt();
    rst = 1'b0; iVld = 1'b0;
    @(negedge clk);
    checks++;
    if (oVld !== 1'b0 || oDat !== 8'h5A || oCnt !== 2'd0) begin
      errors++;
      $display("FAIL mrst got %b/%h/%0d want 0/5a/0", oVld, oDat, oCnt);
    end
    nxt();
    nxt();
    nxt();
    @(negedge clk);
    checks++;
    if (oVld !== 1'b0) begin
      errors++; $display("FAIL mrst_drop got %b want 0", oVld);
    end
    nxt();
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [$];
    logic [7:0] e;
    for (int j = 0; j < 300; j++) begin
      iVld = ($urandom_range(0, 3) != 0);
      iRdy = ($urandom_range(0, 2) != 0);
      iDat = 8'($urandom);
      @(negedge clk);
      checks++;
      if (oCnt !== ec(q.size())) begin
        errors++;
        $display("FAIL b2b_cnt c%0d got %0d want %0d",
                 j, oCnt, ec(q.size()));
      end
      if (oVld && iRdy) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_dup c%0d got %h want none", j, oDat);
        end else begin
          e = q.pop_front();
          if (oDat !== e) begin
            errors++;
            $display("FAIL b2b_dat c%0d got %h want %h", j, oDat, e);
          end
        end
      end
      if (iVld && oRdy) q.push_back(iDat);
      nxt();
    end
    iVld = 1'b0; iRdy = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (oVld && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (oDat !== e) begin
          errors++;
          $display("FAIL b2b_drain got %h want %h", oDat, e);
        end
      end
      nxt();
    end
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL b2b_lost got %0d left want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_clear();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
